// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetcher with in-order memory handshake, FIFO buffering and redirect flush
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_O = (AW+1)'(MAX_OUT);
  localparam logic [AW+1:0] DEP = (AW+2)'(DEPTH);
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [AW:0] count_q, count_d, outstanding_q, outstanding_d, discard_q, discard_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] pc_mem_q [DEPTH];
  logic [31:0] pc_mem_d [DEPTH];
  logic [31:0] ins_mem_q [DEPTH];
  logic [31:0] ins_mem_d [DEPTH];
  logic resp, redir, issue, push, pop;
  logic [31:0] new_pc;
  assign imem_req = enable && rst && !redirect && outstanding_q < MAX_O &&
                    ({1'b0, count_q} + {1'b0, outstanding_q}) < DEP;
  assign imem_addr = fetch_pc_q;
  assign out_valid = count_q != '0;
  assign out_pc = pc_mem_q[rd_ptr_q];
  assign out_instruction = ins_mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    resp = imem_rvalid && outstanding_q != '0;
    redir = redirect && enable;
    issue = imem_req && imem_gnt;
    push = resp && discard_q == '0 && !redir;
    pop = out_valid && out_ready && enable && !redirect;
    new_pc = {redirect_pc[31:2], 2'b00};
    outstanding_d = outstanding_q + (AW+1)'(issue) - (AW+1)'(resp);
    discard_d = redir ? outstanding_q - (AW+1)'(resp)
                      : discard_q - (AW+1)'(resp && discard_q != '0);
    fetch_pc_d = redir ? new_pc : fetch_pc_q + (issue ? 32'd4 : 32'd0);
    resp_pc_d = redir ? new_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
    count_d = redir ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = redir ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = redir ? '0 : rd_ptr_q + AW'(pop);
    pc_mem_d = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q] = resp_pc_q;
      ins_mem_d[wr_ptr_q] = imem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      count_q <= '0;
      outstanding_q <= '0;
      discard_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pc_mem_q <= '{default: '0};
      ins_mem_q <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      count_q <= count_d;
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pc_mem_q <= pc_mem_d;
      ins_mem_q <= ins_mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: cycle-by-cycle directed vectors for the prefetch queue
module tb_fetch_prefetch_queue;
  typedef struct {
    logic rst, en, rd;
    logic [31:0] rpc;
    logic gnt, rv;
    logic [31:0] rdata;
    logic rdy;
    logic req;
    logic [31:0] addr;
    logic ov, hd;
    logic [31:0] opc, oins;
    logic [2:0] cnt;
  } vec_t;
  logic clk = 0, rst = 0, enable = 1, redirect = 0, imem_gnt = 0, imem_rvalid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, out_valid;
  logic [31:0] imem_addr, out_pc, out_instruction;
  logic [2:0] count;
  int checks = 0, errors = 0;
  vec_t tv [36];
  vec_t hs [8];
  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
    .out_ready(out_ready), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  function automatic vec_t mk(input logic r, e, d, input logic [31:0] rp, input logic g, v,
                              input logic [31:0] rdt, input logic y, input logic q,
                              input logic [31:0] a, input logic o, h, input logic [31:0] p, i,
                              input logic [2:0] c);
    vec_t t;
    t.rst = r; t.en = e; t.rd = d; t.rpc = rp; t.gnt = g; t.rv = v; t.rdata = rdt; t.rdy = y;
    t.req = q; t.addr = a; t.ov = o; t.hd = h; t.opc = p; t.oins = i; t.cnt = c;
    return t;
  endfunction
  task automatic chk(input string tag, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", tag, row, act, exp);
    end
  endtask
  task automatic apply(input vec_t t, input int row);
    @(negedge clk);
    rst = t.rst; enable = t.en; redirect = t.rd; redirect_pc = t.rpc; imem_gnt = t.gnt;
    imem_rvalid = t.rv; imem_rdata = t.rdata; out_ready = t.rdy;
    #1;
    chk("imem_req", row, 32'(imem_req), 32'(t.req));
    chk("imem_addr", row, imem_addr, t.addr);
    chk("out_valid", row, 32'(out_valid), 32'(t.ov));
    chk("count", row, 32'(count), 32'(t.cnt));
    if (t.hd) begin
      chk("out_pc", row, out_pc, t.opc);
      chk("out_instruction", row, out_instruction, t.oins);
    end
  endtask
  initial begin
    tv[0]  = mk(0,1,0,0,     1,0,0,1,           0,0,     0,1,0,0,1'b0);
    tv[1]  = mk(1,1,0,0,     1,0,0,1,           1,0,     0,0,0,0,0);
    tv[2]  = mk(1,1,0,0,     1,1,ins(0),1,      1,4,     0,0,0,0,0);
    tv[3]  = mk(1,1,0,0,     1,1,ins(4),1,      1,8,     1,1,0,ins(0),1);
    tv[4]  = mk(1,1,0,0,     1,1,ins(8),1,      1,12,    1,1,4,ins(4),1);
    tv[5]  = mk(1,1,0,0,     1,1,ins(12),0,     1,16,    1,1,8,ins(8),1);
    tv[6]  = mk(1,1,0,0,     1,1,ins(16),0,     1,20,    1,1,8,ins(8),2);
    tv[7]  = mk(1,1,0,0,     1,1,ins(20),0,     0,24,    1,1,8,ins(8),3);
    tv[8]  = mk(1,1,0,0,     1,0,0,0,           0,24,    1,1,8,ins(8),4);
    tv[9]  = mk(1,1,0,0,     1,0,0,1,           0,24,    1,1,8,ins(8),4);
    tv[10] = mk(1,1,0,0,     1,0,0,1,           1,24,    1,1,12,ins(12),3);
    tv[11] = mk(1,1,0,0,     1,1,ins(24),1,     1,28,    1,1,16,ins(16),2);
    tv[12] = mk(1,1,0,0,     1,1,ins(28),1,     1,32,    1,1,20,ins(20),2);
    tv[13] = mk(1,1,0,0,     1,0,0,1,           1,36,    1,1,24,ins(24),2);
    tv[14] = mk(1,1,1,'h100, 1,0,0,1,           0,40,    1,1,28,ins(28),1);
    tv[15] = mk(1,1,0,0,     1,1,ins(32),1,     0,'h100, 0,0,0,0,0);
    tv[16] = mk(1,1,0,0,     1,1,ins(36),1,     1,'h100, 0,0,0,0,0);
    tv[17] = mk(1,1,0,0,     1,1,ins('h100),1,  1,'h104, 0,0,0,0,0);
    tv[18] = mk(1,1,0,0,     1,1,ins('h104),0,  1,'h108, 1,1,'h100,ins('h100),1);
    tv[19] = mk(1,1,1,'h203, 1,1,ins('h108),0,  0,'h10C, 1,1,'h100,ins('h100),2);
    tv[20] = mk(1,1,0,0,     1,0,0,1,           1,'h200, 0,0,0,0,0);
    tv[21] = mk(1,1,0,0,     0,1,ins('h200),1,  1,'h204, 0,0,0,0,0);
    tv[22] = mk(1,1,0,0,     0,0,0,0,           1,'h204, 1,1,'h200,ins('h200),1);
    tv[23] = mk(1,1,0,0,     0,0,0,0,           1,'h204, 1,1,'h200,ins('h200),1);
    tv[24] = mk(1,1,0,0,     1,0,0,0,           1,'h204, 1,1,'h200,ins('h200),1);
    tv[25] = mk(1,1,0,0,     1,1,ins('h204),0,  1,'h208, 1,1,'h200,ins('h200),1);
    tv[26] = mk(1,0,1,'h400, 1,0,0,1,           0,'h20C, 1,1,'h200,ins('h200),2);
    tv[27] = mk(1,0,0,0,     1,1,ins('h208),1,  0,'h20C, 1,1,'h200,ins('h200),2);
    tv[28] = mk(1,1,0,0,     1,0,0,1,           1,'h20C, 1,1,'h200,ins('h200),3);
    tv[29] = mk(1,1,0,0,     1,0,0,0,           1,'h210, 1,1,'h204,ins('h204),2);
    tv[30] = mk(1,1,0,0,     1,1,ins('h20C),0,  0,'h214, 1,1,'h204,ins('h204),2);
    tv[31] = mk(0,1,0,0,     1,0,0,0,           0,'h214, 1,1,'h204,ins('h204),3);
    tv[32] = mk(1,1,0,0,     0,1,ins('h210),1,  1,0,     0,1,0,0,0);
    tv[33] = mk(1,1,0,0,     1,1,'hDEADBEEF,1,  1,0,     0,0,0,0,0);
    tv[34] = mk(1,1,0,0,     0,1,ins(0),1,      1,4,     0,0,0,0,0);
    tv[35] = mk(1,1,0,0,     0,0,0,0,           1,4,     1,1,0,ins(0),1);
    hs[0] = mk(1,1,0,0,     1,0,0,0,           1,4,     1,1,0,ins(0),1);
    hs[1] = mk(1,1,0,0,     1,0,0,0,           1,8,     1,1,0,ins(0),1);
    hs[2] = mk(1,1,1,'h300, 1,0,0,0,           0,12,    1,1,0,ins(0),1);
    hs[3] = mk(1,1,1,'h400, 1,1,ins(4),0,      0,'h300, 0,0,0,0,0);
    hs[4] = mk(1,1,0,0,     0,1,ins(8),0,      1,'h400, 0,0,0,0,0);
    hs[5] = mk(1,1,0,0,     1,0,0,0,           1,'h400, 0,0,0,0,0);
    hs[6] = mk(1,1,0,0,     0,1,ins('h400),0,  1,'h404, 0,0,0,0,0);
    hs[7] = mk(1,1,0,0,     0,0,0,0,           1,'h404, 1,1,'h400,ins('h400),1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 36; i++) apply(tv[i], i);
    for (int i = 0; i < 8; i++) apply(hs[i], 100 + i);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
